z16_dmem_arbiter: RTL and testbench
===================================

// Module: z16_dmem_arbiter
// PURPOSE
//  Shares the single Z16 data-memory port between two requesters:
//   port 0 = Z16 CPU load/store path; port 1 = program loader / DMA engine.
//  Registered owner FSM, round-robin on ties, optional lock for bursts with bounded hold.
//  Sits between the requesters and the data memory (1-cycle synchronous read).
// PARAMETERS
//  AW       16  address width (bits)
//  DW       16  data width (bits)
//  MAX_HOLD 8   max accepted beats per locked tenure while the other port waits (>=1)
// PORTS
//  i_clk        in   1   clock, all state on rising edge
//  i_rst_n      in   1   asynchronous active-low reset
//  i_req0/1     in   1   access request, held until granted
//  i_we0/1      in   1   1 = write, 0 = read (qualified by req)
//  i_lock0/1    in   1   keep ownership for next beat (burst)
//  i_addr0/1    in   AW  byte address
//  i_wdata0/1   in   DW  write data
//  o_gnt0/1     out  1   beat accepted this cycle (req & gnt = transfer)
//  o_rvalid0/1  out  1   read data valid (one cycle after accepted read)
//  o_rdata0/1   out  DW  read data, = i_mem_rdata, meaningful only with rvalid
//  o_mem_addr   out  AW  memory address (owner's addr; 0 when IDLE)
//  o_mem_wen    out  1   memory write enable
//  o_mem_wdata  out  DW  memory write data (owner's wdata; 0 when IDLE)
//  i_mem_rdata  in   DW  memory read data, valid cycle after address
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, last_owner=1 (port 0 wins first tie),
//   hold_cnt=0, o_gnt*=0, o_rvalid*=0, o_mem_wen=0; in-flight read is dropped.
//  States IDLE, OWN0, OWN1 (registered). o_gntN = (state==OWNN) & i_reqN (comb).
//  o_mem_wen = accepted beat & owner's we; addr/wdata muxed by state.
//  IDLE: no req -> IDLE; one req -> OWN of that port; both -> port != last_owner.
//   One-cycle arbitration latency: first grant earliest cycle after req rises.
//  OWNn, other port = m:
//   - !i_reqn: -> OWNm if i_reqm, else IDLE.
//   - i_reqn & !i_reqm: stay OWNn (back-to-back beats at 1/cycle).
//   - i_reqn & i_reqm & !i_lockn: beat accepted, then -> OWNm.
//   - i_reqn & i_reqm & i_lockn: stay while hold_cnt < MAX_HOLD-1; on the
//     beat where hold_cnt == MAX_HOLD-1, accept it, then -> OWNm (forced yield).
//  hold_cnt: +1 per accepted beat while other port requests; clears on any
//   owner change or IDLE; saturates, never wraps.
//  last_owner updates to n on every exit from OWNn.
//  o_rvalidN registered: =1 cycle after an accepted read by port N, else 0.
//   Read return never blocks a new grant; switching owner does not corrupt
//   a pending rvalid (tagged to issuing port).
//  Simultaneous write by owner and request by other: write completes first.
//  No combinational path from i_mem_rdata to any grant.
// TESTING
//  1 Reset with both reqs high -> gnt0 first cycle after release, gnt1 next
//    cycle (port0 unlocked), then alternate 0,1,0,1 while both held.
//  2 Port0 write addr 0x0010 data 0xBEEF, then read 0x0010 -> o_mem_wen=1
//    one cycle; rvalid0=1 with rdata0=0xBEEF one cycle after read grant.
//  3 Port1 locked burst of 20 beats, port0 requesting from beat 3 -> port1
//    gets exactly MAX_HOLD=8 contended beats, then gnt0 next cycle.
//  4 Port1 read granted, owner switches to port0 next cycle -> rvalid1=1
//    (not rvalid0) in that cycle, gnt0=1 same cycle.
//  5 Assert i_rst_n=0 mid-burst (read in flight) -> all gnt/rvalid/wen 0
//    immediately, no rvalid after release; arbitration restarts at IDLE.
//  6 Single requester port0, 5 consecutive reads -> 5 gnts in 5 cycles,
//    hold_cnt stays 0, no forced yield.

Source files
------------

// File: rtl/z16_dmem_arbiter.sv
// z16_dmem_arbiter: shares one synchronous data-memory port between the CPU (port 0)
// and the loader/DMA (port 1); round-robin on ties, lockable bursts with bounded hold.
module z16_dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic          i_lock0,
    input  logic          i_lock1,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_gnt0,
    output logic          o_gnt1,
    output logic          o_rvalid0,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wen,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_e        state_q, state_d, oth;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rvalid0_q, rvalid1_q;
    logic          own1, req_own, req_oth, lock_own;

    assign o_gnt0      = (state_q == OWN0) & i_req0;
    assign o_gnt1      = (state_q == OWN1) & i_req1;
    assign o_mem_wen   = (o_gnt0 & i_we0) | (o_gnt1 & i_we1);
    assign o_mem_addr  = state_q == OWN0 ? i_addr0 : state_q == OWN1 ? i_addr1 : '0;
    assign o_mem_wdata = state_q == OWN0 ? i_wdata0 : state_q == OWN1 ? i_wdata1 : '0;
    assign o_rdata0    = i_mem_rdata;
    assign o_rdata1    = i_mem_rdata;
    assign o_rvalid0   = rvalid0_q;
    assign o_rvalid1   = rvalid1_q;

    assign own1     = state_q == OWN1;
    assign req_own  = own1 ? i_req1 : i_req0;
    assign req_oth  = own1 ? i_req0 : i_req1;
    assign lock_own = own1 ? i_lock1 : i_lock0;
    assign oth      = own1 ? OWN0 : OWN1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (state_q == IDLE)
            state_d = i_req0 & i_req1 ? (last_q ? OWN0 : OWN1) : i_req0 ? OWN0 : i_req1 ? OWN1 : IDLE;
        else if (!req_own)
            state_d = req_oth ? oth : IDLE;
        else if (req_oth && (!lock_own || hold_q >= HW'(MAX_HOLD - 1)))
            state_d = oth;
        // hold counts contended beats of the current tenure only
        if (state_q != IDLE && req_own && req_oth && hold_q != HW'(MAX_HOLD))
            hold_d = hold_q + HW'(1);
        if (state_d != state_q || state_d == IDLE)
            hold_d = '0;
        if (state_q != IDLE && state_d != state_q)
            last_d = own1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= o_gnt0 & ~i_we0;
            rvalid1_q <= o_gnt1 & ~i_we1;
        end
    end
endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// tb_z16_dmem_arbiter: directed scenarios plus random traffic, each cycle compared
// against a tenure-level model of the arbiter and a reference memory.
module tb_z16_dmem_arbiter;
    localparam int MH = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rv0, rv1, mwen;
    logic [15:0] rdata0, rdata1, maddr, mwdata, mrdata;
    logic [15:0] mem [0:255] = '{default: 16'h0};
    logic [15:0] ref_mem [0:255];

    int checks = 0, failures = 0;
    int own, last, streak;
    bit p0, p1, eg0, eg1;
    logic [15:0] pd0, pd1;
    logic obs_g0, obs_g1, obs_wen, obs_rv0, obs_rv1;
    logic [15:0] obs_rd0;

    z16_dmem_arbiter #(.AW(16), .DW(16), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_lock0(lock0), .i_lock1(lock1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_mem_addr(maddr), .o_mem_wen(mwen), .o_mem_wdata(mwdata), .i_mem_rdata(mrdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mwen) mem[maddr[7:0]] <= mwdata;
        mrdata <= mem[maddr[7:0]];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; streak = 0; p0 = 0; p1 = 0; eg0 = 0; eg1 = 0;
    endtask

    // Tenure model: owner index (-1 idle), contended beats in this tenure, last owner.
    task automatic advance();
        int ng;
        bit rn, rm, lk;
        p0 = eg0 && !we0;
        p1 = eg1 && !we1;
        if (p0) pd0 = ref_mem[addr0[7:0]];
        if (p1) pd1 = ref_mem[addr1[7:0]];
        if (eg0 && we0) ref_mem[addr0[7:0]] = wdata0;
        if (eg1 && we1) ref_mem[addr1[7:0]] = wdata1;
        if (own < 0) begin
            ng = (req0 && req1) ? (last == 1 ? 0 : 1) : req0 ? 0 : req1 ? 1 : -1;
        end else begin
            rn = own == 0 ? req0 : req1;
            rm = own == 0 ? req1 : req0;
            lk = own == 0 ? lock0 : lock1;
            if (rn && rm) streak++;
            if (!rn) ng = rm ? 1 - own : -1;
            else if (!rm) ng = own;
            else if (!lk || streak >= MH) ng = 1 - own;
            else ng = own;
            if (ng != own) last = own;
        end
        if (ng != own || ng < 0) streak = 0;
        own = ng;
    endtask

    // Called right after a falling edge with inputs already applied.
    task automatic cycle();
        logic [15:0] ea, ew;
        #2;
        eg0 = own == 0 && req0;
        eg1 = own == 1 && req1;
        ea = own == 0 ? addr0 : own == 1 ? addr1 : 16'h0;
        ew = own == 0 ? wdata0 : own == 1 ? wdata1 : 16'h0;
        obs_g0 = gnt0; obs_g1 = gnt1; obs_wen = mwen; obs_rv0 = rv0; obs_rv1 = rv1; obs_rd0 = rdata0;
        chk1("gnt0", gnt0, eg0);
        chk1("gnt1", gnt1, eg1);
        chk1("mem_wen", mwen, (eg0 && we0) || (eg1 && we1));
        chk16("mem_addr", maddr, ea);
        chk16("mem_wdata", mwdata, ew);
        chk1("rvalid0", rv0, p0);
        chk1("rvalid1", rv1, p1);
        if (p0) chk16("rdata0", rdata0, pd0);
        if (p1) chk16("rdata1", rdata1, pd1);
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    initial begin
        int beats, cont, n;
        bit got0, prev_g1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        model_reset();
        // reset state with both ports requesting
        req0 = 1; req1 = 1;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_rvalid0", rv0, 1'b0);
        chk1("rst_rvalid1", rv1, 1'b0);
        chk1("rst_wen", mwen, 1'b0);
        chk16("rst_addr", maddr, 16'h0);
        @(negedge clk);
        rst_n = 1;
        // 1: tie goes to port 0 first, then strict alternation
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk1("t1_gnt0", obs_g0, k % 2 == 1);
            chk1("t1_gnt1", obs_g1, k != 0 && k % 2 == 0);
        end
        req0 = 0; req1 = 0;
        cycle();
        // 2: write then read back through port 0
        req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
        cycle();
        chk1("t2_wen_arb", obs_wen, 1'b0);
        cycle();
        chk1("t2_wen", obs_wen, 1'b1);
        we0 = 0;
        cycle();
        chk1("t2_read_gnt", obs_g0, 1'b1);
        chk1("t2_wen_read", obs_wen, 1'b0);
        req0 = 0;
        cycle();
        chk1("t2_rvalid0", obs_rv0, 1'b1);
        chk16("t2_rdata0", obs_rd0, 16'hBEEF);
        // 3: locked port-1 burst, port 0 joins on beat 3
        req1 = 1; lock1 = 1; we1 = 1; we0 = 0; addr0 = 16'h0030;
        beats = 0; cont = 0; got0 = 0; prev_g1 = 0;
        for (int c = 0; c < 60 && !got0; c++) begin
            req0 = beats >= 2;
            addr1 = 16'(beats + 64); wdata1 = 16'($urandom);
            cycle();
            if (obs_g0) begin
                got0 = 1;
                chk1("t3_gnt0_after_last_beat", prev_g1, 1'b1);
            end
            if (obs_g1) begin
                beats++;
                if (req0) cont++;
            end
            prev_g1 = obs_g1;
        end
        chk1("t3_port0_served", got0, 1'b1);
        chkn("t3_contended_beats", cont, MH);
        req0 = 0;
        for (int c = 0; c < 60 && beats < 20; c++) begin
            addr1 = 16'(beats + 64); wdata1 = 16'($urandom);
            cycle();
            if (obs_g1) beats++;
        end
        chkn("t3_burst_beats", beats, 20);
        req1 = 0; lock1 = 0;
        cycle();
        // 4: port-1 read in flight while ownership moves to port 0
        req1 = 1; we1 = 0; addr1 = 16'h0045;
        cycle();
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        cycle();
        chk1("t4_gnt1", obs_g1, 1'b1);
        req1 = 0;
        cycle();
        chk1("t4_gnt0", obs_g0, 1'b1);
        chk1("t4_rvalid1", obs_rv1, 1'b1);
        chk1("t4_rvalid0", obs_rv0, 1'b0);
        req0 = 0;
        cycle();
        // 5: reset during a read burst
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 16'h0010;
        cycle();
        cycle();
        #2;
        chk1("t5_pre_rvalid0", rv0, 1'b1);
        rst_n = 0;
        #1;
        chk1("t5_gnt0", gnt0, 1'b0);
        chk1("t5_gnt1", gnt1, 1'b0);
        chk1("t5_rvalid0", rv0, 1'b0);
        chk1("t5_rvalid1", rv1, 1'b0);
        chk1("t5_wen", mwen, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk1("t5_idle_gnt0", obs_g0, 1'b0);
        chk1("t5_no_rvalid", obs_rv0, 1'b0);
        cycle();
        chk1("t5_restart_gnt0", obs_g0, 1'b1);
        // 6: lone requester streams reads at one per cycle
        lock0 = 0; n = 0;
        for (int k = 0; k < 5; k++) begin
            addr0 = 16'(k + 8);
            cycle();
            if (obs_g0) n++;
        end
        chkn("t6_gnts", n, 5);
        req0 = 0;
        cycle();
        // random traffic; a pending request is held until the model grants it
        for (int c = 0; c < 800; c++) begin
            if (!req0 || eg0) begin
                req0 = $urandom_range(0, 3) != 0; we0 = 1'($urandom); lock0 = $urandom_range(0, 2) != 0;
                addr0 = 16'($urandom_range(0, 31)); wdata0 = 16'($urandom);
            end
            if (!req1 || eg1) begin
                req1 = $urandom_range(0, 3) != 0; we1 = 1'($urandom); lock1 = $urandom_range(0, 2) != 0;
                addr1 = 16'($urandom_range(0, 31)); wdata1 = 16'($urandom);
            end
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
